// File: rtl/decoder_pkg.sv
// Shared constants for the decoder_scan block.
// Contents: MODE_DIRECT / MODE_SCAN encodings for the mode input.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable.
// Ports:
//   sel_i : N-bit index to decode
//   en_i  : when low the output is all-zero
//   y_o   : [0:2^N-1] one-hot result, y_o[k] high when sel_i == k
module decoder_onehot #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        sel_i,
  input  logic                en_i,
  output logic [0:(1<<N)-1]   y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[sel_i] = 1'b1;
  end

endmodule : decoder_onehot

// File: rtl/decoder_scan.sv
// Index register with direct-load and dwell-timed scan modes, decoded to a
// one-hot output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   w          : select value captured when load is high
//   e          : enable; low blanks y and pauses the scan
//   load       : capture strobe for w (wins over a scan advance)
//   mode       : 0 = direct, 1 = scan
//   dwell      : cycles-minus-one each index is held while scanning
//   mask       : (DECODER_SCAN_MASK_EN only) mask[k] = 1 skips/blanks index k
//   y          : one-hot of idx, gated by the registered enable
//   idx        : current index
//   wrap       : one-cycle pulse when a scan advance wraps around
// Build option: define DECODER_SCAN_MASK_EN to add the mask input.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [0:(1<<N)-1]   mask,
`endif
  input  logic [N-1:0]        w,
  input  logic                e,
  input  logic                load,
  input  logic                mode,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [0:(1<<N)-1]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_q;
  logic               mode_q;
  logic               wrap_q, wrap_d;

  // Next scan index and whether reaching it counts as a wrap.
  logic [N-1:0]       nxt_idx;
  logic               nxt_wraps;
  logic               adv_blocked;
  logic               idx_visible;

`ifdef DECODER_SCAN_MASK_EN
  localparam int unsigned NUM = 1 << N;

  // First unmasked index above idx_q, searching circularly.
  always_comb begin
    logic [N-1:0] cand;
    logic         found;
    cand    = '0;
    found   = 1'b0;
    nxt_idx = idx_q;
    for (int unsigned off = 1; off <= NUM; off++) begin
      cand = N'(32'(idx_q) + off);
      if (!found && !mask[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign nxt_wraps   = (nxt_idx <= idx_q);
  assign adv_blocked = &mask;
  assign idx_visible = en_q && !mask[idx_q];
`else
  assign nxt_idx     = idx_q + N'(1);
  assign nxt_wraps   = &idx_q;
  assign adv_blocked = 1'b0;
  assign idx_visible = en_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      mode_q <= MODE_DIRECT;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      en_q   <= e;
      mode_q <= mode;
      wrap_q <= wrap_d;
    end
  end

  // Next-state: load beats mode-change clear, which beats the dwell advance.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (mode == MODE_DIRECT) begin
      cnt_d = '0;
      if (load) idx_d = w;
    end else if (load) begin
      idx_d = w;
      cnt_d = '0;
    end else if (mode != mode_q) begin
      cnt_d = '0;
    end else if (e) begin
      if (cnt_q == dwell) begin
        cnt_d = '0;
        if (!adv_blocked) begin
          idx_d  = nxt_idx;
          wrap_d = nxt_wraps;
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // Output decode from registered state.
  decoder_onehot #(
    .N (N)
  ) u_onehot (
    .sel_i (idx_q),
    .en_i  (idx_visible),
    .y_o   (y)
  );

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (N = 4, DWELL_W = 8).
// Mask scenarios are compiled in only when DECODER_SCAN_MASK_EN is defined.
module tb_decoder_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  w;
  logic        e;
  logic        load;
  logic        mode;
  logic [7:0]  dwell;
  logic [0:15] y;
  logic [3:0]  idx;
  logic        wrap;
`ifdef DECODER_SCAN_MASK_EN
  logic [0:15] mask;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  decoder_scan #(
    .N       (4),
    .DWELL_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DECODER_SCAN_MASK_EN
    .mask  (mask),
`endif
    .w     (w),
    .e     (e),
    .load  (load),
    .mode  (mode),
    .dwell (dwell),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:15] oh(input int k);
    logic [0:15] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Check idx, y (with enable assumed high) and wrap together.
  task automatic check_state(input string tag, input int exp_idx, input logic exp_wrap);
    check({tag, ".idx"}, 32'(idx), 32'(exp_idx));
    check({tag, ".y"}, 32'(y), 32'(oh(exp_idx)));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  int          scan_idx  [7] = '{14, 14, 15, 15, 15, 0, 0};
  logic        scan_wrap [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    w = '0; e = 1'b0; load = 1'b0; mode = 1'b0; dwell = '0;
`ifdef DECODER_SCAN_MASK_EN
    mask = '0;
`endif

    // Reset values
    tick();
    tick();
    check("rst.idx", 32'(idx), 32'd0);
    check("rst.y", 32'(y), 32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;

    // Direct load of 9, visible one cycle later
    mode = 1'b0; e = 1'b1; load = 1'b1; w = 4'd9;
    tick();
    check_state("direct.load9", 9, 1'b0);
    load = 1'b0; w = 4'd3;
    tick();
    check_state("direct.hold", 9, 1'b0);
    e = 1'b0;
    tick();
    check("direct.blank.y", 32'(y), 32'd0);
    check("direct.blank.idx", 32'(idx), 32'd9);
    e = 1'b1;
    tick();
    check_state("direct.unblank", 9, 1'b0);

    // Scan with dwell 2 starting from 14 (load wins over the mode-change clear)
    mode = 1'b1; dwell = 8'd2; load = 1'b1; w = 4'd14;
    tick();
    check_state("scan.start", 14, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_state($sformatf("scan.step%0d", i), scan_idx[i], scan_wrap[i]);
    end

    // idx 0, cnt 1: one more hold, then load lands on the advance cycle
    tick();
    check_state("prio.pre", 0, 1'b0);
    load = 1'b1; w = 4'd5;
    tick();
    check_state("prio.load5", 5, 1'b0);
    load = 1'b0;
    tick();
    check_state("prio.cnt1", 5, 1'b0);
    tick();
    check_state("prio.cnt2", 5, 1'b0);
    tick();
    check_state("prio.adv", 6, 1'b0);

    // Pause for 4 cycles with cnt at 1
    tick();
    check_state("pause.pre", 6, 1'b0);
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pause.y%0d", i), 32'(y), 32'd0);
      check($sformatf("pause.idx%0d", i), 32'(idx), 32'd6);
    end
    e = 1'b1;
    tick();
    check_state("pause.resume", 6, 1'b0);
    tick();
    check_state("pause.adv", 7, 1'b0);

    // dwell 0 advances every cycle
    dwell = 8'd0;
    tick();
    check_state("dwell0.a", 8, 1'b0);
    tick();
    check_state("dwell0.b", 9, 1'b0);

    // Mode change clears the count but keeps idx
    dwell = 8'd3;
    tick();
    tick();
    check_state("mchg.cnt2", 9, 1'b0);
    mode = 1'b0;
    tick();
    check_state("mchg.direct", 9, 1'b0);
    mode = 1'b1;
    tick();
    check_state("mchg.scan", 9, 1'b0);
    tick();
    tick();
    tick();
    check_state("mchg.cnt3", 9, 1'b0);
    tick();
    check_state("mchg.adv", 10, 1'b0);

`ifdef DECODER_SCAN_MASK_EN
    // Indices 4..7 masked, dwell 0, scan from 3
    dwell = 8'd0; load = 1'b1; w = 4'd3;
    for (int k = 4; k <= 7; k++) mask[k] = 1'b1;
    tick();
    check_state("mask.start", 3, 1'b0);
    load = 1'b0;
    for (int k = 8; k <= 16; k++) begin
      tick();
      check_state($sformatf("mask.to%0d", k % 16), k % 16, (k == 16) ? 1'b1 : 1'b0);
    end
    mask = '1;
    tick();
    check("mask.all.idx", 32'(idx), 32'd0);
    check("mask.all.y", 32'(y), 32'd0);
    check("mask.all.wrap", 32'(wrap), 32'd0);
    tick();
    check("mask.all.hold", 32'(idx), 32'd0);
    mask = '0;
    load = 1'b1; w = 4'd10; dwell = 8'd3;
    tick();
    load = 1'b0;
`endif

    // Asynchronous reset mid-scan, then restart with a full dwell
    check("prerst.idx", 32'(idx), 32'd10);
    dwell = 8'd2;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.idx", 32'(idx), 32'd0);
    check("arst.y", 32'(y), 32'd0);
    check("arst.wrap", 32'(wrap), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_state("restart.a", 0, 1'b0);
    tick();
    tick();
    check_state("restart.b", 0, 1'b0);
    tick();
    check_state("restart.adv", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_decoder_scan
